// File: rtl/imembus_wbp_pipe_if.sv
// Pipelined Wishbone read-side bus bundle between the fetch adapter and the
// instruction interconnect.
interface imembus_wbp_pipe_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [SEL_WIDTH-1:0]  sel;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_wr;
   logic [DATA_WIDTH-1:0] data_rd;
   logic                  ack;
   logic                  err;
   logic                  stall;

   modport master (
      output cyc, stb, we, sel, addr, data_wr,
      input  data_rd, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, sel, addr, data_wr,
      output data_rd, ack, err, stall
   );
endinterface

// File: rtl/imembus_wbp_pipe.sv
// Instruction-fetch adapter: turns fetch requests into pipelined Wishbone
// reads with up to MAX_OUTSTANDING in flight, returns responses in order and
// drops responses belonging to reads issued before a flush.
module imembus_wbp_pipe #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   imembus_wbp_pipe_if.master    wb,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_re,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [ADDR_WIDTH-1:0] o_read_addr,
   output logic                  o_error,
   output logic                  o_unaligned,
   output logic                  o_busy
);
   localparam int OFFS = $clog2(DATA_WIDTH / 8);
   localparam int CW   = $clog2(MAX_OUTSTANDING) + 1;
   localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

   logic [CW-1:0]         count_reg, count_next;
   logic [CW-1:0]         disc_reg, disc_next;
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_WIDTH-1:0] addr_fifo [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] data_hold_reg;
   logic [ADDR_WIDTH-1:0] addr_hold_reg;
   logic                  err_hold_reg;
   logic                  unaligned_reg;

   logic misaligned, full, req_ok, push, pop, deliver;
   logic [DATA_WIDTH-1:0] resp_data;

   // Pointer wrap that also works when the depth is not 2**PW (depth 1).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign misaligned = |i_addr[OFFS-1:0];
   // Only the registered count gates the strobe, so an ack can never
   // combinationally open a slot in the same cycle.
   assign full       = (count_reg == MAX_CNT);
   assign req_ok     = i_re && !misaligned && !full;
   assign push       = req_ok && !wb.stall;
   assign pop        = (wb.ack || wb.err) && (count_reg != '0);
   // A response arriving in a flush cycle belongs to a pre-flush read.
   assign deliver    = pop && (disc_reg == '0) && !i_flush;
   assign resp_data  = wb.err ? '0 : wb.data_rd;

   assign wb.stb     = req_ok;
   assign wb.cyc     = req_ok || (count_reg != '0);
   assign wb.we      = 1'b0;
   assign wb.sel     = '1;
   assign wb.addr    = i_addr;
   assign wb.data_wr = '0;

   assign o_stall     = full || wb.stall;
   assign o_valid     = deliver;
   assign o_data      = deliver ? resp_data : data_hold_reg;
   assign o_read_addr = deliver ? addr_fifo[rd_ptr_reg] : addr_hold_reg;
   assign o_error     = deliver ? wb.err : err_hold_reg;
   assign o_unaligned = unaligned_reg;
   assign o_busy      = (count_reg != '0);

   // Next in-flight count and discard count; a flush marks everything that
   // was outstanding at the start of the cycle (minus this cycle's pop).
   always_comb begin
      count_next = count_reg + CW'(push) - CW'(pop);
      disc_next  = disc_reg;
      if (i_flush)
         disc_next = count_reg - CW'(pop);
      else if (pop && (disc_reg != '0))
         disc_next = disc_reg - CW'(1);
   end

   // Counters, FIFO pointers, held response and misalignment flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_reg     <= '0;
         disc_reg      <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         data_hold_reg <= '0;
         addr_hold_reg <= '0;
         err_hold_reg  <= 1'b0;
         unaligned_reg <= 1'b0;
      end else begin
         count_reg     <= count_next;
         disc_reg      <= disc_next;
         unaligned_reg <= i_re && misaligned;
         if (push)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (deliver) begin
            data_hold_reg <= resp_data;
            addr_hold_reg <= addr_fifo[rd_ptr_reg];
            err_hold_reg  <= wb.err;
         end
      end
   end

   // Address FIFO storage; no reset needed since the pointers qualify it.
   always_ff @(posedge i_clk) begin
      if (push)
         addr_fifo[wr_ptr_reg] <= i_addr;
   end

`ifdef VERIFICATION
   logic                  chk_hold_reg;
   logic [ADDR_WIDTH-1:0] chk_addr_reg;

   // Protocol checks on the fetch side and on the bus responses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         chk_hold_reg <= 1'b0;
         chk_addr_reg <= '0;
      end else begin
         chk_hold_reg <= i_re && o_stall;
         chk_addr_reg <= i_addr;
         if ((wb.ack || wb.err) && (count_reg == '0))
            $error("imembus_wbp_pipe: response with nothing outstanding");
         if (chk_hold_reg && i_re && (i_addr != chk_addr_reg))
            $error("imembus_wbp_pipe: i_addr changed while stalled");
         if (count_reg > MAX_CNT)
            $error("imembus_wbp_pipe: outstanding count overflow");
      end
   end
`endif

endmodule

// File: tb/tb_imembus_wbp_pipe.sv
// Directed bench for imembus_wbp_pipe: the bench itself plays the Wishbone
// slave, driving ack/err/stall/data_rd by hand each cycle.
module tb_imembus_wbp_pipe;
   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_addr;
   logic        i_re;
   logic        i_flush;
   logic        o_stall;
   logic        o_valid;
   logic [31:0] o_data;
   logic [31:0] o_read_addr;
   logic        o_error;
   logic        o_unaligned;
   logic        o_busy;

   int total = 0;
   int bad   = 0;

   imembus_wbp_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb_bus ();

   imembus_wbp_pipe #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MAX_OUTSTANDING(4)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .wb(wb_bus),
      .i_addr(i_addr),
      .i_re(i_re),
      .i_flush(i_flush),
      .o_stall(o_stall),
      .o_valid(o_valid),
      .o_data(o_data),
      .o_read_addr(o_read_addr),
      .o_error(o_error),
      .o_unaligned(o_unaligned),
      .o_busy(o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst_n        = 1'b0;
      i_addr         = '0;
      i_re           = 1'b0;
      i_flush        = 1'b0;
      wb_bus.ack     = 1'b0;
      wb_bus.err     = 1'b0;
      wb_bus.stall   = 1'b0;
      wb_bus.data_rd = '0;

      // ---- reset state
      #2;
      check("rst_cyc", wb_bus.cyc, 0);
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_unal", o_unaligned, 0);
      check("rst_data", o_data, 0);
      check("rst_raddr", o_read_addr, 0);
      check("rst_err", o_error, 0);
      check("rst_we", wb_bus.we, 0);
      check("rst_sel", wb_bus.sel, 4'hf);
      tick(); tick();
      i_rst_n = 1'b1;
      tick();

      // ---- zero-wait slave, three back-to-back fetches
      i_re = 1'b1; i_addr = 32'h0;
      #1;
      check("zw_stb0", wb_bus.stb, 1);
      check("zw_stall0", o_stall, 0);
      check("zw_valid0", o_valid, 0);
      check("zw_cyc0", wb_bus.cyc, 1);
      tick();
      i_addr = 32'h4; wb_bus.ack = 1'b1; wb_bus.data_rd = 32'hA000_0000;
      #1;
      check("zw_stb1", wb_bus.stb, 1);
      check("zw_valid1", o_valid, 1);
      check("zw_raddr1", o_read_addr, 32'h0);
      check("zw_data1", o_data, 32'hA000_0000);
      tick();
      i_addr = 32'h8; wb_bus.data_rd = 32'hA000_0004;
      #1;
      check("zw_valid2", o_valid, 1);
      check("zw_raddr2", o_read_addr, 32'h4);
      tick();
      i_re = 1'b0; wb_bus.data_rd = 32'hA000_0008;
      #1;
      check("zw_valid3", o_valid, 1);
      check("zw_raddr3", o_read_addr, 32'h8);
      check("zw_stb3", wb_bus.stb, 0);
      tick();
      wb_bus.ack = 1'b0;
      #1;
      check("zw_valid4", o_valid, 0);
      check("zw_busy4", o_busy, 0);
      check("zw_hdata", o_data, 32'hA000_0008);
      check("zw_hraddr", o_read_addr, 32'h8);
      check("zw_cyc4", wb_bus.cyc, 0);

      // ---- fill to MAX, fifth request waits for a slot
      for (int i = 0; i < 4; i++) begin
         tick();
         i_re = 1'b1; i_addr = 32'h10 + 32'(4 * i);
         #1;
         check("full_stb", wb_bus.stb, 1);
         check("full_stall", o_stall, 0);
      end
      tick();
      i_addr = 32'h20;
      #1;
      check("full_stb5", wb_bus.stb, 0);
      check("full_ostall5", o_stall, 1);
      check("full_busy5", o_busy, 1);
      tick();
      #1;
      check("full_ostall6", o_stall, 1);
      tick();
      wb_bus.ack = 1'b1; wb_bus.data_rd = 32'hB0;
      #1;
      check("full_ackstall", o_stall, 1);
      check("full_ackstb", wb_bus.stb, 0);
      check("full_ackvalid", o_valid, 1);
      check("full_ackraddr", o_read_addr, 32'h10);
      tick();
      wb_bus.ack = 1'b0;
      #1;
      check("full_accstall", o_stall, 0);
      check("full_accstb", wb_bus.stb, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         i_re = 1'b0; wb_bus.ack = 1'b1; wb_bus.data_rd = 32'hB0 + 32'(4 * i);
         #1;
         check("drain_valid", o_valid, 1);
         check("drain_raddr", o_read_addr, 32'h10 + 32'(4 * i));
         check("drain_data", o_data, 32'hB0 + 32'(4 * i));
         check("drain_busy", o_busy, 1);
      end
      tick();
      wb_bus.ack = 1'b0;
      #1;
      check("drain_idle", o_busy, 0);
      check("drain_valid_end", o_valid, 0);

      // ---- flush with three outstanding (one acking in the flush cycle)
      for (int i = 0; i < 3; i++) begin
         tick();
         i_re = 1'b1; i_addr = 32'h30 + 32'(4 * i);
      end
      tick();
      i_flush = 1'b1; i_addr = 32'h100; wb_bus.ack = 1'b1; wb_bus.data_rd = 32'hC0;
      #1;
      check("fl_valid0", o_valid, 0);
      check("fl_stb0", wb_bus.stb, 1);
      check("fl_stall0", o_stall, 0);
      tick();
      i_flush = 1'b0; i_re = 1'b0; wb_bus.data_rd = 32'hC4;
      #1;
      check("fl_valid1", o_valid, 0);
      check("fl_busy1", o_busy, 1);
      tick();
      wb_bus.data_rd = 32'hC8;
      #1;
      check("fl_valid2", o_valid, 0);
      tick();
      wb_bus.data_rd = 32'hCC;
      #1;
      check("fl_valid3", o_valid, 1);
      check("fl_raddr3", o_read_addr, 32'h100);
      check("fl_data3", o_data, 32'hCC);
      tick();
      wb_bus.ack = 1'b0;
      #1;
      check("fl_busy4", o_busy, 0);
      check("fl_hdata", o_data, 32'hCC);

      // ---- error on the second of two reads
      tick();
      i_re = 1'b1; i_addr = 32'h40;
      tick();
      i_addr = 32'h44;
      tick();
      i_re = 1'b0; wb_bus.ack = 1'b1; wb_bus.data_rd = 32'h11;
      #1;
      check("er_valid0", o_valid, 1);
      check("er_err0", o_error, 0);
      check("er_data0", o_data, 32'h11);
      check("er_raddr0", o_read_addr, 32'h40);
      tick();
      wb_bus.ack = 1'b0; wb_bus.err = 1'b1; wb_bus.data_rd = 32'hDEAD;
      #1;
      check("er_valid1", o_valid, 1);
      check("er_err1", o_error, 1);
      check("er_data1", o_data, 0);
      check("er_raddr1", o_read_addr, 32'h44);
      tick();
      wb_bus.err = 1'b0;
      #1;
      check("er_valid2", o_valid, 0);
      check("er_herr", o_error, 1);
      check("er_hdata", o_data, 0);
      check("er_hraddr", o_read_addr, 32'h44);

      // ---- misaligned fetch
      tick();
      i_re = 1'b1; i_addr = 32'h102;
      #1;
      check("un_stb", wb_bus.stb, 0);
      check("un_cyc", wb_bus.cyc, 0);
      check("un_flag0", o_unaligned, 0);
      tick();
      i_re = 1'b0;
      #1;
      check("un_flag1", o_unaligned, 1);
      check("un_busy", o_busy, 0);
      tick();
      #1;
      check("un_flag2", o_unaligned, 0);

      // ---- bus stall, then reset with two reads outstanding
      wb_bus.stall = 1'b1; i_re = 1'b1; i_addr = 32'h200;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_ostall", o_stall, 1);
         check("st_stb", wb_bus.stb, 1);
         check("st_busy", o_busy, 0);
         tick();
      end
      wb_bus.stall = 1'b0;
      #1;
      check("st_release", o_stall, 0);
      check("st_stb_rel", wb_bus.stb, 1);
      tick();
      i_addr = 32'h204;
      #1;
      check("st_stb2", wb_bus.stb, 1);
      tick();
      i_re = 1'b0;
      #1;
      check("st_busy2", o_busy, 1);
      check("st_cyc2", wb_bus.cyc, 1);
      #1;
      i_rst_n = 1'b0;
      #1;
      check("rs_cyc", wb_bus.cyc, 0);
      check("rs_busy", o_busy, 0);
      check("rs_valid", o_valid, 0);
      tick();
      wb_bus.ack = 1'b1; wb_bus.data_rd = 32'hEE;
      #1;
      check("rs_late_valid", o_valid, 0);
      check("rs_late_cyc", wb_bus.cyc, 0);
      tick();
      wb_bus.ack = 1'b0; i_rst_n = 1'b1;
      #1;
      check("rs_busy2", o_busy, 0);
      check("rs_cyc2", wb_bus.cyc, 0);
      tick();
      #1;
      check("rs_hraddr", o_read_addr, 0);
      check("rs_herr", o_error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
